// File: rtl/io_input_cond.sv
// rtl/io_input_cond.sv - switch synchroniser and button debouncer for the LSU input-peripheral path
//
// Purpose:
//   Synchronises the raw board switches into the core clock domain.
//   Synchronises and debounces the push buttons.
//   Optionally adds sticky press flags and one-cycle press pulses.
//
// Optional feature macro:
//   IO_INPUT_COND_EDGE_EN - when defined, the press flags/pulses are built.
//                           When undefined, o_btn_press/o_btn_pulse are tied
//                           to 0 and i_press_clr is ignored.
//
// Ports:
//   i_clk        - core clock
//   i_rst        - asynchronous active-high reset
//   i_sw_raw     - asynchronous switch pins
//   i_btn_raw    - asynchronous button pins (active low when BTN_ACTIVE_LOW=1)
//   i_press_clr  - per-bit synchronous clear of the sticky press flags
//   o_io_sw      - synchronised switches
//   o_io_btn     - debounced active-high buttons
//   o_btn_press  - sticky flag, set on a debounced press
//   o_btn_pulse  - one-cycle pulse on a debounced press

module io_input_cond #(
  parameter int SW_WIDTH        = 32,
  parameter int BTN_WIDTH       = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [SW_WIDTH-1:0]  i_sw_raw,
  input  logic [BTN_WIDTH-1:0] i_btn_raw,
  input  logic [BTN_WIDTH-1:0] i_press_clr,
  output logic [SW_WIDTH-1:0]  o_io_sw,
  output logic [BTN_WIDTH-1:0] o_io_btn,
  output logic [BTN_WIDTH-1:0] o_btn_press,
  output logic [BTN_WIDTH-1:0] o_btn_pulse
);

  // Counter only has to reach DEBOUNCE_CYCLES-1, so clog2 bits suffice.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Switches: plain 2-flop synchroniser
  // ---------------------------------------------------------------------------
  logic [SW_WIDTH-1:0] sw_meta;
  logic [SW_WIDTH-1:0] sw_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= i_sw_raw;
      sw_sync <= sw_meta;
    end
  end

  assign o_io_sw = sw_sync;

  // ---------------------------------------------------------------------------
  // Buttons: normalise to active-high before synchronising, so the reset
  // value 0 of the synchroniser always means "released".
  // ---------------------------------------------------------------------------
  logic [BTN_WIDTH-1:0] btn_in;
  logic [BTN_WIDTH-1:0] btn_meta;
  logic [BTN_WIDTH-1:0] btn_s;

  assign btn_in = BTN_ACTIVE_LOW ? ~i_btn_raw : i_btn_raw;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      btn_meta <= '0;
      btn_s    <= '0;
    end else begin
      btn_meta <= btn_in;
      btn_s    <= btn_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-button debounce: q follows s only after s has disagreed with q for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  // ---------------------------------------------------------------------------
  logic [BTN_WIDTH-1:0] q;
  logic [BTN_WIDTH-1:0] q_next;
  logic [CNT_W-1:0]     cnt      [BTN_WIDTH];
  logic [CNT_W-1:0]     cnt_next [BTN_WIDTH];

  always_comb begin
    for (int i = 0; i < BTN_WIDTH; i++) begin
      q_next[i]   = q[i];
      cnt_next[i] = '0;
      if (btn_s[i] != q[i]) begin
        if (cnt[i] == CNT_LAST) begin
          q_next[i] = btn_s[i];
        end else begin
          cnt_next[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      q <= '0;
      for (int i = 0; i < BTN_WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      q <= q_next;
      for (int i = 0; i < BTN_WIDTH; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  assign o_io_btn = q;

  // ---------------------------------------------------------------------------
  // Press detection
  // ---------------------------------------------------------------------------
`ifdef IO_INPUT_COND_EDGE_EN
  logic [BTN_WIDTH-1:0] rise;
  logic [BTN_WIDTH-1:0] press_r;
  logic [BTN_WIDTH-1:0] pulse_r;

  // Registering rise lines the pulse up with the first cycle o_io_btn reads 1.
  assign rise = q_next & ~q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      press_r <= '0;
      pulse_r <= '0;
    end else begin
      // Set has priority over clear so a press coinciding with a clear is kept.
      press_r <= (press_r & ~i_press_clr) | rise;
      pulse_r <= rise;
    end
  end

  assign o_btn_press = press_r;
  assign o_btn_pulse = pulse_r;
`else
  logic unused_press_clr;
  assign unused_press_clr = ^i_press_clr;

  assign o_btn_press = '0;
  assign o_btn_pulse = '0;
`endif

endmodule

// File: tb/tb_io_input_cond.sv
// tb/tb_io_input_cond.sv - scoreboard bench for io_input_cond with a history-window reference model
module tb_io_input_cond;

  localparam int SW_W  = 32;
  localparam int BTN_W = 4;
  localparam int DB    = 4;
`ifdef IO_INPUT_COND_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [SW_W-1:0]  sw_raw;
  logic [BTN_W-1:0] btn_raw;
  logic [BTN_W-1:0] press_clr;
  logic [SW_W-1:0]  io_sw;
  logic [BTN_W-1:0] io_btn;
  logic [BTN_W-1:0] btn_press;
  logic [BTN_W-1:0] btn_pulse;

  always #5 clk = ~clk;

  io_input_cond #(
    .SW_WIDTH       (SW_W),
    .BTN_WIDTH      (BTN_W),
    .DEBOUNCE_CYCLES(DB),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_sw_raw   (sw_raw),
    .i_btn_raw  (btn_raw),
    .i_press_clr(press_clr),
    .o_io_sw    (io_sw),
    .o_io_btn   (io_btn),
    .o_btn_press(btn_press),
    .o_btn_pulse(btn_pulse)
  );

  typedef struct packed {
    logic [SW_W-1:0]  sw;
    logic [BTN_W-1:0] btn;
    logic [BTN_W-1:0] press;
    logic [BTN_W-1:0] pulse;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: inputs seen at each clock edge since the last reset.
  // Outputs are derived from these histories: switches are the input from
  // one edge earlier; a button state flips when the DB most recent
  // synchronised samples (input delayed by two edges) all disagree with it.
  logic [SW_W-1:0]  m_sw_hist[$];
  logic [BTN_W-1:0] m_btn_hist[$];
  logic [BTN_W-1:0] m_q     = '0;
  logic [BTN_W-1:0] m_press = '0;

  task automatic model_edge(input logic r, input logic [SW_W-1:0] sw,
                            input logic [BTN_W-1:0] btn, input logic [BTN_W-1:0] clr);
    exp_t             e;
    logic [BTN_W-1:0] rise;
    e    = '0;
    rise = '0;
    if (r) begin
      m_sw_hist.delete();
      m_btn_hist.delete();
      m_q     = '0;
      m_press = '0;
    end else begin
      m_sw_hist.push_back(sw);
      if (m_sw_hist.size() > 2) void'(m_sw_hist.pop_front());
      m_btn_hist.push_back(~btn);
      if (m_btn_hist.size() > DB + 2) void'(m_btn_hist.pop_front());
      for (int b = 0; b < BTN_W; b++) begin
        bit flip;
        flip = 1'b1;
        for (int j = 0; j < DB; j++) begin
          int   idx;
          logic v;
          idx = m_btn_hist.size() - 3 - j;
          v   = (idx >= 0) ? m_btn_hist[idx][b] : 1'b0;
          if (v == m_q[b]) flip = 1'b0;
        end
        if (flip) begin
          rise[b] = ~m_q[b];
          m_q[b]  = ~m_q[b];
        end
      end
      if (EDGE_EN) m_press = (m_press & ~clr) | rise;
      e.sw    = (m_sw_hist.size() == 2) ? m_sw_hist[0] : '0;
      e.btn   = m_q;
      e.press = m_press;
      e.pulse = EDGE_EN ? rise : '0;
    end
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [SW_W-1:0] act, input logic [SW_W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one expectation per edge, compared away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("o_io_sw",     io_sw,               e.sw);
      chk("o_io_btn",    {28'd0, io_btn},     {28'd0, e.btn});
      chk("o_btn_press", {28'd0, btn_press},  {28'd0, e.press});
      chk("o_btn_pulse", {28'd0, btn_pulse},  {28'd0, e.pulse});
    end
  end

  task automatic step(input logic r, input logic [SW_W-1:0] sw,
                      input logic [BTN_W-1:0] btn, input logic [BTN_W-1:0] clr);
    rst       = r;
    sw_raw    = sw;
    btn_raw   = btn;
    press_clr = clr;
    model_edge(r, sw, btn, clr);
    @(negedge clk);
    #1;
  endtask

  task automatic hold(input int n, input logic [SW_W-1:0] sw, input logic [BTN_W-1:0] btn);
    for (int i = 0; i < n; i++) step(1'b0, sw, btn, 4'h0);
  endtask

  initial begin
    logic [SW_W-1:0]  sw_r;
    logic [BTN_W-1:0] btn_r;
    // Reset state
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 4'hF, 4'h0);

    // Switch sync
    hold(4, 32'hA5A5_0F0F, 4'hF);

    // Clean press on button 0, then release (flag stays)
    hold(8, $urandom, 4'hE);
    hold(8, $urandom, 4'hF);

    // Glitch rejection on button 1
    hold(3, $urandom, 4'hD);
    hold(1, $urandom, 4'hF);
    hold(3, $urandom, 4'hD);
    hold(8, $urandom, 4'hF);

    // Press button 2, release, clear its flag
    hold(8, $urandom, 4'hB);
    hold(8, $urandom, 4'hF);
    step(1'b0, $urandom, 4'hF, 4'h4);
    hold(2, $urandom, 4'hF);
    // Press again so that the rise edge (6th edge) coincides with the clear
    for (int i = 0; i < 5; i++) step(1'b0, $urandom, 4'hB, 4'h0);
    step(1'b0, $urandom, 4'hB, 4'h4);
    hold(3, $urandom, 4'hB);
    hold(8, $urandom, 4'hF);

    // Reset mid-count on button 3, button held through reset
    hold(4, $urandom, 4'h7);
    step(1'b1, $urandom, 4'h7, 4'h0);
    step(1'b1, $urandom, 4'h7, 4'h0);
    hold(8, $urandom, 4'h7);
    hold(8, $urandom, 4'hF);

    // Randomised phase: button patterns held for random lengths
    btn_r = 4'hF;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) btn_r = 4'($urandom);
      sw_r = $urandom;
      step(($urandom_range(0, 99) == 0), sw_r, btn_r,
           ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0);
    end
    hold(2, 32'h0, 4'hF);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
